// File: rtl/fsm_decoder.sv
// Receive-side mirror of the 2-bit Mealy symbol FSM: recovers X bits from the
// Y symbol stream, packs them LSB-first into words and counts illegal symbols.
module fsm_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sym_valid,
  input  logic [1:0]        sym,
  input  logic              resync,
  output logic              x_out,
  output logic              x_valid,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        state,
  output logic              lost,
  output logic [CNT_W-1:0]  err_cnt
);

  // Handshake: sym is consumed on any edge where sym_valid=1, resync=0 and
  // lost=0 (no backpressure); x_valid/word_valid are single-cycle pulses.
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic              dec_legal;
  logic              dec_x;
  logic [1:0]        dec_next;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;

  always_comb begin
    dec_legal = 1'b0;
    dec_x     = 1'b0;
    dec_next  = state;
    case (state)
      S0: case (sym)
        2'b01: begin dec_legal = 1'b1; dec_x = 1'b0; dec_next = S0; end
        2'b00: begin dec_legal = 1'b1; dec_x = 1'b1; dec_next = S2; end
        default: ;
      endcase
      S1: case (sym)
        2'b00: begin dec_legal = 1'b1; dec_x = 1'b0; dec_next = S0; end
        2'b01: begin dec_legal = 1'b1; dec_x = 1'b1; dec_next = S1; end
        default: ;
      endcase
      S2: case (sym)
        2'b10: begin dec_legal = 1'b1; dec_x = 1'b0; dec_next = S1; end
        2'b00: begin dec_legal = 1'b1; dec_x = 1'b1; dec_next = S0; end
        default: ;
      endcase
      default: case (sym)
        2'b10: begin dec_legal = 1'b1; dec_x = 1'b0; dec_next = S3; end
        2'b00: begin dec_legal = 1'b1; dec_x = 1'b1; dec_next = S3; end
        default: ;
      endcase
    endcase
  end

  // Partial word lives in acc so that word only changes on completion.
  always_comb begin
    acc_next          = acc;
    acc_next[bit_idx] = dec_x;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S0;
      lost       <= 1'b0;
      err_cnt    <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      word       <= '0;
      x_out      <= 1'b0;
      x_valid    <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      x_valid    <= 1'b0;
      word_valid <= 1'b0;
      if (resync) begin
        state   <= S0;
        lost    <= 1'b0;
        bit_idx <= '0;
      end else if (sym_valid && !lost) begin
        if (dec_legal) begin
          x_out   <= dec_x;
          x_valid <= 1'b1;
          state   <= dec_next;
          acc     <= acc_next;
          if (bit_idx == LAST_IDX) begin
            word       <= acc_next;
            word_valid <= 1'b1;
            bit_idx    <= '0;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end else begin
          lost    <= 1'b1;
          bit_idx <= '0;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_decoder.sv
// Bench for fsm_decoder: directed scenarios plus random symbols checked
// against a table-driven reference model and an expected-word queue.
module tb_fsm_decoder;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              sym_valid;
  logic [1:0]        sym;
  logic              resync;
  logic              x_out;
  logic              x_valid;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic [1:0]        state;
  logic              lost;
  logic [CNT_W-1:0]  err_cnt;

  fsm_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
    .resync(resync), .x_out(x_out), .x_valid(x_valid), .word(word),
    .word_valid(word_valid), .state(state), .lost(lost), .err_cnt(err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  int tbl_x  [4][4];
  int tbl_nx [4][4];   // -1 marks an illegal (state, sym) pair

  int                m_state;
  bit                m_lost;
  int                m_err;
  bit                m_x, m_xv, m_wv;
  logic [DATA_W-1:0] m_word;
  bit                bits_q[$];
  logic [DATA_W-1:0] exp_q[$];

  task automatic build_table();
    for (int s = 0; s < 4; s++)
      for (int y = 0; y < 4; y++) begin
        tbl_x[s][y] = 0; tbl_nx[s][y] = -1;
      end
    tbl_x[0][1] = 0; tbl_nx[0][1] = 0;  tbl_x[0][0] = 1; tbl_nx[0][0] = 2;
    tbl_x[1][0] = 0; tbl_nx[1][0] = 0;  tbl_x[1][1] = 1; tbl_nx[1][1] = 1;
    tbl_x[2][2] = 0; tbl_nx[2][2] = 1;  tbl_x[2][0] = 1; tbl_nx[2][0] = 0;
    tbl_x[3][2] = 0; tbl_nx[3][2] = 3;  tbl_x[3][0] = 1; tbl_nx[3][0] = 3;
  endtask

  task automatic model_reset();
    m_state = 0; m_lost = 0; m_err = 0;
    m_x = 0; m_xv = 0; m_wv = 0; m_word = '0;
    bits_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input int s, input bit rs);
    m_xv = 0; m_wv = 0;
    if (rs) begin
      m_state = 0; m_lost = 0; bits_q.delete();
    end else if (v && !m_lost) begin
      if (tbl_nx[m_state][s] >= 0) begin
        m_x  = tbl_x[m_state][s][0];
        m_xv = 1;
        m_state = tbl_nx[m_state][s];
        bits_q.push_back(m_x);
        if (bits_q.size() == DATA_W) begin
          m_word = '0;
          for (int i = 0; i < DATA_W; i++)
            if (bits_q[i]) m_word = m_word + (DATA_W'(1) << i);
          m_wv = 1;
          exp_q.push_back(m_word);
          bits_q.delete();
        end
      end else begin
        m_lost = 1;
        if (m_err < ERR_MAX) m_err++;
        bits_q.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; sym_valid = 1'b0; resync = 1'b0; sym = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // One accepted-or-not cycle; the scoreboard consumes completed words here.
  task automatic step(input bit v, input logic [1:0] s, input bit rs);
    logic [DATA_W-1:0] w;
    @(negedge clk);
    sym_valid = v; sym = s; resync = rs;
    @(posedge clk); #1;
    sym_valid = 1'b0; resync = 1'b0;
    model_step(v, int'(s), rs);
    if (word_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: word_valid with word=%h but no word expected", word);
      end else begin
        w = exp_q.pop_front();
        if (word !== w) begin
          errors++;
          $display("FAIL scoreboard_word: got %h expected %h", word, w);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; sym_valid = 1'b0; resync = 1'b0; sym = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({x_out, x_valid, word, word_valid, state, lost, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values: x_out=%b x_valid=%b word=%h wv=%b state=%0d lost=%b err=%0d, all must be 0",
               x_out, x_valid, word, word_valid, state, lost, err_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 2'b00, 1'b0);
    checks++;
    if (state !== 2'd0 || x_valid !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d x_valid=%b lost=%b expected 0 0 0", state, x_valid, lost);
    end
  endtask

  task automatic test_decode_seq();
    logic [1:0] syms [5] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
    bit         xs   [5] = '{0, 1, 0, 1, 0};
    logic [1:0] sts  [5] = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, syms[i], 1'b0);
      checks++;
      if (x_valid !== 1'b1 || x_out !== xs[i] || state !== sts[i]) begin
        errors++;
        $display("FAIL decode_seq[%0d]: x_valid=%b x_out=%b state=%0d expected 1 %b %0d",
                 i, x_valid, x_out, state, xs[i], sts[i]);
      end
    end
  endtask

  task automatic send_word_6a(input string tag);
    logic [1:0] syms [8] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, syms[i], 1'b0);
      checks++;
      if (word_valid !== (i == 7) || x_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_pulse[%0d]: word_valid=%b x_valid=%b expected %b 1",
                 tag, i, word_valid, x_valid, (i == 7));
      end
    end
    checks++;
    if (word !== 8'h6A) begin
      errors++;
      $display("FAIL %s_word: got %h expected 6a", tag, word);
    end
  endtask

  task automatic test_word();
    apply_reset();
    send_word_6a("word");
  endtask

  task automatic test_illegal();
    apply_reset();
    step(1'b1, 2'b10, 1'b0);
    checks++;
    if (lost !== 1'b1 || err_cnt !== 8'd1 || x_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal: lost=%b err_cnt=%0d x_valid=%b expected 1 1 0", lost, err_cnt, x_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      checks++;
      if (x_valid !== 1'b0 || err_cnt !== 8'd1 || lost !== 1'b1) begin
        errors++;
        $display("FAIL lost_ignore[%0d]: x_valid=%b err_cnt=%0d lost=%b expected 0 1 1",
                 i, x_valid, err_cnt, lost);
      end
    end
    step(1'b0, 2'b00, 1'b1);
    checks++;
    if (state !== 2'd0 || lost !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL resync: state=%0d lost=%b err_cnt=%0d expected 0 0 1", state, lost, err_cnt);
    end
    step(1'b1, 2'b00, 1'b0);
    checks++;
    if (x_valid !== 1'b1 || x_out !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL recover: x_valid=%b x_out=%b state=%0d expected 1 1 2", x_valid, x_out, state);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2'b11, 1'b0);
      step(1'b0, 2'b00, 1'b1);
    end
    checks++;
    if (err_cnt !== CNT_W'(ERR_MAX) || err_cnt !== CNT_W'(m_err)) begin
      errors++;
      $display("FAIL saturate: err_cnt=%0d expected %0d", err_cnt, ERR_MAX);
    end
    step(1'b1, 2'b11, 1'b0);
    checks++;
    if (err_cnt !== CNT_W'(ERR_MAX) || lost !== 1'b1) begin
      errors++;
      $display("FAIL saturate_hold: err_cnt=%0d lost=%b expected %0d 1", err_cnt, lost, ERR_MAX);
    end
    step(1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_resync_priority();
    logic [DATA_W-1:0] held;
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    held = word;
    step(1'b1, 2'b00, 1'b1);
    checks++;
    if (state !== 2'd0 || x_valid !== 1'b0 || word !== held) begin
      errors++;
      $display("FAIL resync_priority: state=%0d x_valid=%b word=%h expected 0 0 %h",
               state, x_valid, word, held);
    end
    send_word_6a("resync_idx");
  endtask

  task automatic test_reset_midword();
    apply_reset();
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);   // nonzero err_cnt and lost before the pulse
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({x_out, x_valid, word, word_valid, state, lost, err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: x_out=%b x_valid=%b word=%h state=%0d lost=%b err=%0d, all must be 0",
               x_out, x_valid, word, state, lost, err_cnt);
    end
    #1 reset = 1'b0;
    model_reset();
    send_word_6a("after_reset");
  endtask

  task automatic test_random();
    bit         v, rs;
    logic [1:0] s;
    int         legal [$];
    for (int n = 0; n < 800; n++) begin
      v  = ($urandom_range(0, 9) < 8);
      rs = ($urandom_range(0, 19) == 0) || (m_lost && $urandom_range(0, 3) == 0);
      legal.delete();
      for (int y = 0; y < 4; y++) if (tbl_nx[m_state][y] >= 0) legal.push_back(y);
      if ($urandom_range(0, 9) < 9) s = 2'(legal[$urandom_range(0, legal.size() - 1)]);
      else                          s = 2'($urandom_range(0, 3));
      step(v, s, rs);
      checks++;
      if (x_valid !== m_xv || (m_xv && x_out !== m_x) || word_valid !== m_wv ||
          state !== 2'(m_state) || lost !== m_lost || err_cnt !== CNT_W'(m_err) ||
          word !== m_word) begin
        errors++;
        $display("FAIL random[%0d]: xv=%b x=%b wv=%b word=%h st=%0d lost=%b err=%0d expected %b %b %b %h %0d %b %0d",
                 n, x_valid, x_out, word_valid, word, state, lost, err_cnt,
                 m_xv, m_x, m_wv, m_word, m_state, m_lost, m_err);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    build_table();
    test_reset();
    test_decode_seq();
    test_word();
    test_illegal();
    test_saturate();
    test_resync_priority();
    test_reset_midword();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected words never seen, 0 required", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
